// File: rtl/vga_sram_arbiter.sv
// -----------------------------------------------------------------------------
// vga_sram_arbiter
//
// Shares one 512 KiB x 8 asynchronous SRAM between the VGA scan-out engine and
// the CPU memory bridge. Each rising edge of I_vga_clk issues at most one access
// (a "slot"). The slot owner is registered and serviced on the following edge.
// VGA reads always win. CPU reads and writes use the free slots.
//
// Optional feature: define SRAM_ARB_STATS_EN to build the statistics counters.
// Without it, O_stat_* are tied to 0 and I_stat_clr is ignored.
//
// Ports
//   I_vga_clk, I_reset       clock; synchronous active-high reset
//   I_vga_req/_adr           VGA read request pulse and address
//   O_vga_dat/_valid         VGA read data (held) and one-cycle update pulse
//   I_cpu_req/_we/_adr/_dat  CPU request (level until ack), direction, addr, data
//   O_cpu_dat/_ack           CPU read data and one-cycle completion pulse
//   O_sram_adr/_dat          SRAM address pins and write data
//   O_sram_dat_oe            tristate enable for the top-level data bus
//   I_sram_dat               SRAM data bus input
//   O_sram_oe_n/_we_n        SRAM output and write enables, active low
//   I_stat_clr               synchronous clear of the statistics counters
//   O_stat_cpu_stall         CPU cycles lost to VGA (saturating)
//   O_stat_vga_reads         VGA grant count (wrapping)
// -----------------------------------------------------------------------------
module vga_sram_arbiter #(
  parameter int ADR_W = 19,
  parameter int DAT_W = 8
) (
  input  logic             I_vga_clk,
  input  logic             I_reset,
  input  logic             I_vga_req,
  input  logic [ADR_W-1:0] I_vga_adr,
  output logic [DAT_W-1:0] O_vga_dat,
  output logic             O_vga_valid,
  input  logic             I_cpu_req,
  input  logic             I_cpu_we,
  input  logic [ADR_W-1:0] I_cpu_adr,
  input  logic [DAT_W-1:0] I_cpu_dat,
  output logic [DAT_W-1:0] O_cpu_dat,
  output logic             O_cpu_ack,
  output logic [ADR_W-1:0] O_sram_adr,
  output logic [DAT_W-1:0] O_sram_dat,
  output logic             O_sram_dat_oe,
  input  logic [DAT_W-1:0] I_sram_dat,
  output logic             O_sram_oe_n,
  output logic             O_sram_we_n,
  input  logic             I_stat_clr,
  output logic [15:0]      O_stat_cpu_stall,
  output logic [15:0]      O_stat_vga_reads
);

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_VGA    = 2'd1,
    SLOT_CPU_RD = 2'd2,
    SLOT_CPU_WR = 2'd3
  } slot_e;

  slot_e             slot_q, slot_d;
  logic [ADR_W-1:0]  sram_adr_q, sram_adr_d;
  logic [DAT_W-1:0]  sram_dat_q, sram_dat_d;
  logic              sram_dat_oe_q, sram_dat_oe_d;
  logic              sram_oe_n_q, sram_oe_n_d;
  logic              sram_we_n_q, sram_we_n_d;
  logic [DAT_W-1:0]  vga_dat_q, vga_dat_d;
  logic              vga_valid_q, vga_valid_d;
  logic [DAT_W-1:0]  cpu_dat_q, cpu_dat_d;
  logic              cpu_ack_q, cpu_ack_d;

  // A CPU slot being serviced at this edge is the access whose ack is about to
  // be issued; it blocks a new CPU grant. The registered ack seen during the ack
  // cycle does not block, so the requester must drop or re-present I_cpu_req
  // in that cycle and back-to-back accesses complete every two cycles.
  logic cpu_busy;
  logic cpu_grant_ok;

  assign cpu_busy     = (slot_q == SLOT_CPU_RD) || (slot_q == SLOT_CPU_WR);
  assign cpu_grant_ok = I_cpu_req && !cpu_busy;

  always_ff @(posedge I_vga_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed by the always_comb block.
    if (I_reset) begin
      slot_q        <= SLOT_IDLE;
      sram_adr_q    <= '0;
      sram_dat_q    <= '0;
      sram_dat_oe_q <= 1'b0;
      sram_oe_n_q   <= 1'b1;
      sram_we_n_q   <= 1'b1;
      vga_dat_q     <= '0;
      vga_valid_q   <= 1'b0;
      cpu_dat_q     <= '0;
      cpu_ack_q     <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      sram_adr_q    <= sram_adr_d;
      sram_dat_q    <= sram_dat_d;
      sram_dat_oe_q <= sram_dat_oe_d;
      sram_oe_n_q   <= sram_oe_n_d;
      sram_we_n_q   <= sram_we_n_d;
      vga_dat_q     <= vga_dat_d;
      vga_valid_q   <= vga_valid_d;
      cpu_dat_q     <= cpu_dat_d;
      cpu_ack_q     <= cpu_ack_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    slot_d        = SLOT_IDLE;
    sram_adr_d    = sram_adr_q;
    sram_dat_d    = sram_dat_q;
    sram_dat_oe_d = 1'b0;
    sram_oe_n_d   = 1'b1;
    sram_we_n_d   = 1'b1;
    vga_dat_d     = vga_dat_q;
    vga_valid_d   = 1'b0;
    cpu_dat_d     = cpu_dat_q;
    cpu_ack_d     = 1'b0;

    // Service the slot issued on the previous edge. The SRAM has had one full
    // clock period to drive I_sram_dat for a read.
    unique case (slot_q)
      SLOT_VGA: begin
        vga_dat_d   = I_sram_dat;
        vga_valid_d = 1'b1;
      end
      SLOT_CPU_RD: begin
        cpu_dat_d = I_sram_dat;
        cpu_ack_d = 1'b1;
      end
      SLOT_CPU_WR: cpu_ack_d = 1'b1;
      default: ;
    endcase

    // Issue this edge's slot; overrides the idle pin defaults above.
    if (I_vga_req) begin
      slot_d      = SLOT_VGA;
      sram_adr_d  = I_vga_adr;
      sram_oe_n_d = 1'b0;
    end else if (cpu_grant_ok) begin
      sram_adr_d = I_cpu_adr;
      if (I_cpu_we) begin
        slot_d        = SLOT_CPU_WR;
        sram_dat_d    = I_cpu_dat;
        sram_we_n_d   = 1'b0;
        sram_dat_oe_d = 1'b1;
      end else begin
        slot_d      = SLOT_CPU_RD;
        sram_oe_n_d = 1'b0;
      end
    end
  end

  assign O_sram_adr    = sram_adr_q;
  assign O_sram_dat    = sram_dat_q;
  assign O_sram_dat_oe = sram_dat_oe_q;
  assign O_sram_oe_n   = sram_oe_n_q;
  assign O_sram_we_n   = sram_we_n_q;
  assign O_vga_dat     = vga_dat_q;
  assign O_vga_valid   = vga_valid_q;
  assign O_cpu_dat     = cpu_dat_q;
  assign O_cpu_ack     = cpu_ack_q;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] stat_stall_q, stat_stall_d;
  logic [15:0] stat_reads_q, stat_reads_d;
  logic        stall_event;

  // The CPU would have been granted this edge had VGA not taken the slot.
  assign stall_event = cpu_grant_ok && I_vga_req;

  always_ff @(posedge I_vga_clk) begin
    if (I_reset) begin
      stat_stall_q <= '0;
      stat_reads_q <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_reads_q <= stat_reads_d;
    end
  end

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_reads_d = stat_reads_q;
    if (I_stat_clr) begin
      stat_stall_d = '0;
      stat_reads_d = '0;
    end else begin
      if (stall_event && (stat_stall_q != 16'hFFFF))
        stat_stall_d = stat_stall_q + 16'd1;
      if (I_vga_req)
        stat_reads_d = stat_reads_q + 16'd1;
    end
  end

  assign O_stat_cpu_stall = stat_stall_q;
  assign O_stat_vga_reads = stat_reads_q;
`else
  logic stat_clr_unused;
  assign stat_clr_unused  = I_stat_clr;
  assign O_stat_cpu_stall = '0;
  assign O_stat_vga_reads = '0;
`endif

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_sram_arbiter
//
// Directed bench for vga_sram_arbiter with a behavioural asynchronous SRAM.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_vga_sram_arbiter;

  localparam int ADR_W = 19;
  localparam int DAT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             vga_req;
  logic [ADR_W-1:0] vga_adr;
  logic [DAT_W-1:0] vga_dat;
  logic             vga_valid;
  logic             cpu_req;
  logic             cpu_we;
  logic [ADR_W-1:0] cpu_adr;
  logic [DAT_W-1:0] cpu_wdat;
  logic [DAT_W-1:0] cpu_rdat;
  logic             cpu_ack;
  logic [ADR_W-1:0] sram_adr;
  logic [DAT_W-1:0] sram_wdat;
  logic             sram_dat_oe;
  logic [DAT_W-1:0] sram_rdat;
  logic             sram_oe_n;
  logic             sram_we_n;
  logic             stat_clr;
  logic [15:0]      stat_stall;
  logic [15:0]      stat_reads;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DAT_W-1:0] mem [0:(1<<ADR_W)-1];

  always #5 clk = ~clk;

  vga_sram_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .I_vga_clk        (clk),
    .I_reset          (reset),
    .I_vga_req        (vga_req),
    .I_vga_adr        (vga_adr),
    .O_vga_dat        (vga_dat),
    .O_vga_valid      (vga_valid),
    .I_cpu_req        (cpu_req),
    .I_cpu_we         (cpu_we),
    .I_cpu_adr        (cpu_adr),
    .I_cpu_dat        (cpu_wdat),
    .O_cpu_dat        (cpu_rdat),
    .O_cpu_ack        (cpu_ack),
    .O_sram_adr       (sram_adr),
    .O_sram_dat       (sram_wdat),
    .O_sram_dat_oe    (sram_dat_oe),
    .I_sram_dat       (sram_rdat),
    .O_sram_oe_n      (sram_oe_n),
    .O_sram_we_n      (sram_we_n),
    .I_stat_clr       (stat_clr),
    .O_stat_cpu_stall (stat_stall),
    .O_stat_vga_reads (stat_reads)
  );

  // Asynchronous SRAM: reads follow the address while OE is low; a write
  // period ending at a rising edge commits the data held during that period.
  assign sram_rdat = (!sram_oe_n) ? mem[sram_adr] : '0;

  always @(posedge clk)
    if (!sram_we_n) mem[sram_adr] <= sram_wdat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    mem[19'h20000] = 8'hA5;
    mem[19'h00010] = 8'h5A;

    // Reset held with every request active.
    reset    = 1'b1;
    vga_req  = 1'b1;
    vga_adr  = 19'h20000;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_adr  = 19'h00010;
    cpu_wdat = 8'h00;
    stat_clr = 1'b0;
    tick(3);
    check("rst_oe_n",   32'(sram_oe_n),   32'h1);
    check("rst_we_n",   32'(sram_we_n),   32'h1);
    check("rst_dat_oe", 32'(sram_dat_oe), 32'h0);
    check("rst_valid",  32'(vga_valid),   32'h0);
    check("rst_ack",    32'(cpu_ack),     32'h0);
    check("rst_adr",    32'(sram_adr),    32'h0);

    // First edge after reset: VGA wins over the pending CPU request.
    reset = 1'b0;
    tick();
    check("vga_issue_adr",  32'(sram_adr),  32'h20000);
    check("vga_issue_oe_n", 32'(sram_oe_n), 32'h0);
    check("vga_issue_we_n", 32'(sram_we_n), 32'h1);
    vga_req = 1'b0;
    cpu_req = 1'b0;
    tick();
    check("vga_valid",      32'(vga_valid), 32'h1);
    check("vga_dat",        32'(vga_dat),   32'hA5);
    check("vga_idle_oe_n",  32'(sram_oe_n), 32'h1);
    check("vga_idle_adr",   32'(sram_adr),  32'h20000);
    tick();
    check("vga_valid_pulse", 32'(vga_valid), 32'h0);
    check("vga_dat_hold",    32'(vga_dat),   32'hA5);

    // CPU write 0x3C to 0x40001, then read it back.
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_adr  = 19'h40001;
    cpu_wdat = 8'h3C;
    tick();
    check("wr_we_n",   32'(sram_we_n),   32'h0);
    check("wr_oe_n",   32'(sram_oe_n),   32'h1);
    check("wr_dat_oe", 32'(sram_dat_oe), 32'h1);
    check("wr_adr",    32'(sram_adr),    32'h40001);
    check("wr_dat",    32'(sram_wdat),   32'h3C);
    check("wr_ack_early", 32'(cpu_ack),  32'h0);
    // Inputs may change after grant; re-present as a read of the same byte.
    cpu_we   = 1'b0;
    cpu_wdat = 8'hFF;
    tick();
    check("wr_ack",        32'(cpu_ack),     32'h1);
    check("wr_we_n_done",  32'(sram_we_n),   32'h1);
    check("wr_dat_oe_off", 32'(sram_dat_oe), 32'h0);
    check("wr_dat_kept",   32'(sram_wdat),   32'h3C);
    tick();
    check("rd_issue_oe_n",   32'(sram_oe_n),   32'h0);
    check("rd_issue_dat_oe", 32'(sram_dat_oe), 32'h0);
    check("rd_issue_adr",    32'(sram_adr),    32'h40001);
    check("rd_ack_gap",      32'(cpu_ack),     32'h0);
    cpu_req = 1'b0;
    tick();
    check("rd_ack", 32'(cpu_ack),  32'h1);
    check("rd_dat", 32'(cpu_rdat), 32'h3C);
    tick();
    check("rd_ack_pulse", 32'(cpu_ack), 32'h0);

    // Collision: VGA and CPU read on the same edge.
    vga_req = 1'b1;
    vga_adr = 19'h20000;
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    cpu_adr = 19'h00010;
    tick();
    check("col_vga_adr", 32'(sram_adr), 32'h20000);
    vga_req = 1'b0;
    tick();
    check("col_vga_valid", 32'(vga_valid), 32'h1);
    check("col_vga_dat",   32'(vga_dat),   32'hA5);
    check("col_ack_none",  32'(cpu_ack),   32'h0);
    check("col_cpu_adr",   32'(sram_adr),  32'h00010);
    check("col_cpu_oe_n",  32'(sram_oe_n), 32'h0);
    cpu_req = 1'b0;
    tick();
    check("col_cpu_ack",   32'(cpu_ack),   32'h1);
    check("col_cpu_dat",   32'(cpu_rdat),  32'h5A);
    check("col_valid_off", 32'(vga_valid), 32'h0);
    tick();

    // Reset on the edge after a CPU write grant drops the access.
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_adr  = 19'h00123;
    cpu_wdat = 8'h77;
    tick();
    check("rma_we_n_grant", 32'(sram_we_n), 32'h0);
    reset   = 1'b1;
    cpu_req = 1'b0;
    tick();
    check("rma_ack",    32'(cpu_ack),     32'h0);
    check("rma_we_n",   32'(sram_we_n),   32'h1);
    check("rma_dat_oe", 32'(sram_dat_oe), 32'h0);
    reset = 1'b0;
    tick();
    check("rma_ack_after", 32'(cpu_ack), 32'h0);

`ifdef SRAM_ARB_STATS_EN
    // Starvation: VGA every cycle with a CPU request pending.
    begin
      int acks = 0;
      vga_req = 1'b1;
      vga_adr = 19'h20000;
      cpu_req = 1'b1;
      cpu_we  = 1'b0;
      cpu_adr = 19'h00010;
      for (int i = 0; i < 70000; i++) begin
        tick();
        if (cpu_ack) acks++;
      end
      vga_req = 1'b0;
      cpu_req = 1'b0;
      check("starve_acks",  32'(acks),       32'h0);
      check("stat_stall",   32'(stat_stall), 32'hFFFF);
      check("stat_reads",   32'(stat_reads), 32'd4464);
      // Clear coinciding with a count event: clear wins.
      vga_req  = 1'b1;
      stat_clr = 1'b1;
      tick();
      vga_req  = 1'b0;
      stat_clr = 1'b0;
      check("stat_clr_stall", 32'(stat_stall), 32'h0);
      check("stat_clr_reads", 32'(stat_reads), 32'h0);
      tick(2);
    end
`else
    check("stat_stall_tied", 32'(stat_stall), 32'h0);
    check("stat_reads_tied", 32'(stat_reads), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
